// File: rtl/edlo_sequencer.sv
// EDLO program sequencer: holds a small instruction/address program and issues
// each word to the datapath over a valid/ack handshake, with jumps, END and timeout.
module edlo_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_BITS  = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           host_cmd,
    input  logic                 host_valid,
    output logic                 host_ready,
    input  logic [7:0]           host_data,
    output logic [3:0]           op_inst,
    output logic [ADDR_BITS-1:0] op_addr,
    output logic                 op_valid,
    input  logic                 op_ack,
    output logic [ADDR_BITS-1:0] pc,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [1:0] CMD_LOAD = 2'b01;
    localparam logic [1:0] CMD_RUN  = 2'b10;
    localparam logic [1:0] CMD_HALT = 2'b11;
    localparam logic [3:0] OP_JMP   = 4'hE;
    localparam logic [3:0] OP_END   = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE} state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] pc_q, pc_d;
    logic [ADDR_BITS-1:0] wptr_q, wptr_d;
    logic [7:0]           tmo_q, tmo_d;
    logic                 op_valid_q, op_valid_d;
    logic [3:0]           op_inst_q, op_inst_d;
    logic [ADDR_BITS-1:0] op_addr_q, op_addr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [7:0] prog_q [PROG_DEPTH];

    logic [7:0] word;
    logic       is_load, is_run, is_halt;
    logic       ack_fire, tmo_fire;

    assign word     = prog_q[pc_q];
    assign is_load  = host_valid && (host_cmd == CMD_LOAD);
    assign is_run   = host_valid && (host_cmd == CMD_RUN);
    assign is_halt  = host_valid && (host_cmd == CMD_HALT);
    assign ack_fire = (state_q == S_ISSUE) && op_ack;
    // Abort on the edge that would bring the wait count up to TIMEOUT.
    assign tmo_fire = (state_q == S_ISSUE) && !op_ack && (tmo_q == 8'(TIMEOUT - 1));

    // Program store is deliberately left out of reset so a program survives it.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && is_load) begin
            prog_q[wptr_q] <= host_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            wptr_q     <= '0;
            tmo_q      <= '0;
            op_valid_q <= 1'b0;
            op_inst_q  <= '0;
            op_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            wptr_q     <= wptr_d;
            tmo_q      <= tmo_d;
            op_valid_q <= op_valid_d;
            op_inst_q  <= op_inst_d;
            op_addr_q  <= op_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (is_run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (is_halt || word[7:4] == OP_END) state_d = S_IDLE;
                else if (word[7:4] != OP_JMP)       state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (is_halt || tmo_fire) state_d = S_IDLE;
                else if (op_ack)         state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        wptr_d     = wptr_q;
        tmo_d      = tmo_q;
        op_valid_d = op_valid_q;
        op_inst_d  = op_inst_q;
        op_addr_d  = op_addr_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (is_load) begin
                    wptr_d = wptr_q + 1'b1;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                end else if (is_run) begin
                    pc_d   = '0;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                end else if (is_halt) begin
                    wptr_d = '0;
                end
            end
            S_FETCH: begin
                if (is_halt) begin
                    busy_d = 1'b0;
                end else if (word[7:4] == OP_END) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else if (word[7:4] == OP_JMP) begin
                    pc_d = ADDR_BITS'(word[3:0]);
                end else begin
                    op_inst_d  = word[7:4];
                    op_addr_d  = ADDR_BITS'(word[3:0]);
                    op_valid_d = 1'b1;
                    tmo_d      = '0;
                end
            end
            S_ISSUE: begin
                // A same-cycle ack still completes before HALT takes the run down.
                if (ack_fire) begin
                    op_valid_d = 1'b0;
                    pc_d       = pc_q + 1'b1;
                    tmo_d      = '0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
                if (is_halt) begin
                    op_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    tmo_d      = '0;
                end else if (tmo_fire) begin
                    op_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    err_d      = 1'b1;
                    tmo_d      = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        host_ready = 1'b1;
        op_inst    = op_inst_q;
        op_addr    = op_addr_q;
        op_valid   = op_valid_q;
        pc         = pc_q;
        busy       = busy_q;
        done       = done_q;
        err        = err_q;
    end

endmodule

// File: tb/tb_edlo_sequencer.sv
// Directed bench for edlo_sequencer: load/run, jump loop, timeout, delayed ack
// with pc wrap, simultaneous HALT events and mid-run asynchronous reset.
module tb_edlo_sequencer;

    localparam logic [1:0] CMD_LOAD = 2'b01;
    localparam logic [1:0] CMD_RUN  = 2'b10;
    localparam logic [1:0] CMD_HALT = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] host_cmd;
    logic       host_valid;
    logic       host_ready;
    logic [7:0] host_data;
    logic [3:0] op_inst;
    logic [3:0] op_addr;
    logic       op_valid;
    logic       op_ack;
    logic [3:0] pc;
    logic       busy;
    logic       done;
    logic       err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    edlo_sequencer #(.PROG_DEPTH(16), .ADDR_BITS(4), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_cmd   (host_cmd),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_data  (host_data),
        .op_inst    (op_inst),
        .op_addr    (op_addr),
        .op_valid   (op_valid),
        .op_ack     (op_ack),
        .pc         (pc),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] c, input logic [7:0] d);
        host_cmd   = c;
        host_data  = d;
        host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
        host_cmd   = 2'b00;
    endtask

    initial begin
        int cnt;
        int w;
        rst_n      = 1'b0;
        host_cmd   = 2'b00;
        host_valid = 1'b0;
        host_data  = 8'h00;
        op_ack     = 1'b0;
        tick();
        tick();
        check("rst_op_valid", op_valid, 0);
        check("rst_op_inst", op_inst, 0);
        check("rst_op_addr", op_addr, 0);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("host_ready", host_ready, 1);
        rst_n = 1'b1;

        // Load and run with immediate ack
        cmd(CMD_LOAD, 8'h13);
        cmd(CMD_LOAD, 8'h25);
        cmd(CMD_LOAD, 8'hF0);
        op_ack = 1'b1;
        cmd(CMD_RUN, 8'h00);
        check("run_busy", busy, 1);
        check("run_fetch_valid", op_valid, 0);
        tick();
        check("op1_valid", op_valid, 1);
        check("op1_inst", op_inst, 4'h1);
        check("op1_addr", op_addr, 4'h3);
        tick();
        check("op1_ack_valid", op_valid, 0);
        check("op1_ack_pc", pc, 1);
        tick();
        check("op2_valid", op_valid, 1);
        check("op2_inst", op_inst, 4'h2);
        check("op2_addr", op_addr, 4'h5);
        tick();
        check("op2_ack_pc", pc, 2);
        check("pre_end_done", done, 0);
        tick();
        check("end_done", done, 1);
        check("end_err", err, 0);
        check("end_busy", busy, 0);
        check("end_pc", pc, 2);
        check("end_valid", op_valid, 0);
        op_ack = 1'b0;

        // Jump loop: 0x41, JMP 0
        cmd(CMD_HALT, 8'h00);
        cmd(CMD_LOAD, 8'h41);
        check("load_clears_done", done, 0);
        cmd(CMD_LOAD, 8'hE0);
        op_ack = 1'b1;
        cmd(CMD_RUN, 8'h00);
        for (int t = 1; t <= 9; t++) begin
            tick();
            check("jmp_valid", op_valid, ((t % 3) == 1));
            check("jmp_busy", busy, 1);
            if ((t % 3) == 1) begin
                check("jmp_inst", op_inst, 4'h4);
                check("jmp_addr", op_addr, 4'h1);
            end
        end
        cmd(CMD_HALT, 8'h00);
        op_ack = 1'b0;
        check("jmp_halt_busy", busy, 0);
        check("jmp_halt_valid", op_valid, 0);
        check("jmp_halt_done", done, 0);

        // Timeout with no ack
        cmd(CMD_HALT, 8'h00);
        cmd(CMD_LOAD, 8'h37);
        cmd(CMD_RUN, 8'h00);
        tick();
        check("tmo_first_valid", op_valid, 1);
        check("tmo_inst", op_inst, 4'h3);
        check("tmo_addr", op_addr, 4'h7);
        cnt = 1;
        while (op_valid && cnt < 40) begin
            tick();
            if (op_valid) cnt++;
        end
        check("tmo_valid_cycles", cnt, 15);
        check("tmo_err", err, 1);
        check("tmo_done", done, 1);
        check("tmo_busy", busy, 0);
        check("tmo_pc", pc, 0);

        // Delayed ack, all 16 entries, pc wraps
        cmd(CMD_HALT, 8'h00);
        for (int k = 0; k < 16; k++) begin
            cmd(CMD_LOAD, 8'(16 + k));
            if (k == 0) begin
                check("load_clears_err", err, 0);
                check("load_clears_done2", done, 0);
            end
        end
        cmd(CMD_RUN, 8'h00);
        for (int i = 0; i < 18; i++) begin
            w = 0;
            while (!op_valid && w < 6) begin
                tick();
                w++;
            end
            check("wrap_valid", op_valid, 1);
            check("wrap_pc", pc, i % 16);
            check("wrap_inst", op_inst, 4'h1);
            check("wrap_addr", op_addr, i % 16);
            tick();
            check("wrap_hold_valid", op_valid, 1);
            check("wrap_hold_addr", op_addr, i % 16);
            tick();
            check("wrap_hold2_valid", op_valid, 1);
            check("wrap_hold2_inst", op_inst, 4'h1);
            op_ack = 1'b1;
            tick();
            op_ack = 1'b0;
            check("wrap_ack_valid", op_valid, 0);
        end
        cmd(CMD_HALT, 8'h00);
        check("wrap_halt_pc", pc, 2);
        check("wrap_halt_busy", busy, 0);

        // HALT together with ack
        cmd(CMD_HALT, 8'h00);
        cmd(CMD_LOAD, 8'h21);
        cmd(CMD_LOAD, 8'h22);
        cmd(CMD_RUN, 8'h00);
        tick();
        check("ha_valid", op_valid, 1);
        check("ha_addr", op_addr, 4'h1);
        op_ack = 1'b1;
        cmd(CMD_HALT, 8'h00);
        op_ack = 1'b0;
        check("ha_pc", pc, 1);
        check("ha_busy", busy, 0);
        check("ha_valid_low", op_valid, 0);
        check("ha_done", done, 0);

        // HALT on the timeout edge
        cmd(CMD_RUN, 8'h00);
        tick();
        check("ht_valid", op_valid, 1);
        repeat (14) tick();
        check("ht_pre_valid", op_valid, 1);
        cmd(CMD_HALT, 8'h00);
        check("ht_err", err, 0);
        check("ht_done", done, 0);
        check("ht_busy", busy, 0);
        check("ht_valid_low", op_valid, 0);
        check("ht_pc", pc, 0);

        // Mid-run asynchronous reset
        cmd(CMD_RUN, 8'h00);
        tick();
        check("mr_valid", op_valid, 1);
        check("mr_inst", op_inst, 4'h2);
        rst_n = 1'b0;
        #1;
        check("mr_rst_valid", op_valid, 0);
        check("mr_rst_busy", busy, 0);
        check("mr_rst_inst", op_inst, 0);
        check("mr_rst_addr", op_addr, 0);
        check("mr_rst_pc", pc, 0);
        tick();
        rst_n = 1'b1;
        cmd(CMD_RUN, 8'h00);
        tick();
        check("replay_valid", op_valid, 1);
        check("replay_inst", op_inst, 4'h2);
        check("replay_addr", op_addr, 4'h1);
        check("replay_pc", pc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
